// File: rtl/counter_n_param_pkg.sv
// Shared counter encodings: count direction and terminal-count mode.
// Imported by every counter stage so that cascaded stages agree on meaning.
package counter_n_param_pkg;

  // up_down encodings
  localparam logic COUNT_UP     = 1'b1;
  localparam logic COUNT_DOWN   = 1'b0;

  // one_shot encodings
  localparam logic MODE_FREE    = 1'b0;
  localparam logic MODE_ONESHOT = 1'b1;

endpackage : counter_n_param_pkg

// File: rtl/counter_n_param.sv
// Modulo-N up/down counter stage with load, clear, one-shot stop and cascade.
//
// Ports:
//   clk          rising-edge clock
//   reset        asynchronous active-low reset
//   enable       local count enable
//   carry_in     cascade enable from the lower stage (tie 1 when unused)
//   clear        synchronous clear (highest priority)
//   load         synchronous load strobe
//   load_value   value applied on load, clamped to MODULUS-1
//   up_down      1 = count up, 0 = count down
//   one_shot     1 = stop at terminal count, 0 = free-run
//   count_N      current count (registered)
//   carry_out_N  combinational terminal-count cascade output
//   wrapped      sticky flag: a terminal-count event occurred since clear/reset
//   halted       high while a one-shot count is stopped
module counter_n_param
  import counter_n_param_pkg::*;
#(
  parameter int unsigned WIDTH   = 3,
  parameter int unsigned MODULUS = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             carry_in,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             up_down,
  input  logic             one_shot,
  output logic [WIDTH-1:0] count_N,
  output logic             carry_out_N,
  output logic             wrapped,
  output logic             halted
);

  localparam int unsigned     CMP_W = WIDTH + 1;
  localparam logic [WIDTH-1:0] LAST = WIDTH'(MODULUS - 1);

  // Reject parameter combinations the counter cannot represent.
  if (WIDTH < 1 || WIDTH > 31 || MODULUS < 2 || MODULUS > (32'd1 << WIDTH)) begin : g_illegal
    $error("counter_n_param: illegal WIDTH=%0d / MODULUS=%0d", WIDTH, MODULUS);
  end

  logic             running;
  logic             step;
  logic             terminal;
  logic             load_big;
  logic [WIDTH-1:0] count_d;
  logic             wrapped_d;
  logic             halted_d;

  // running goes high on the first edge after reset release, so that edge
  // never counts.
  assign step = enable & carry_in & ~halted & running;

  // Terminal state depends on the current direction.
  always_comb begin
    terminal = 1'b0;
    if (up_down == COUNT_UP) terminal = (count_N == LAST);
    else                     terminal = (count_N == '0);
  end

  // Cascade output is suppressed by clear/load and by reset being held.
  assign carry_out_N = reset & step & terminal & ~clear & ~load;

  // Widened compare so MODULUS == 2**WIDTH fits.
  assign load_big = ({1'b0, load_value} >= CMP_W'(MODULUS));

  // Next-state: clear, then load, then step.
  always_comb begin
    count_d   = count_N;
    wrapped_d = wrapped;
    halted_d  = halted;
    if (clear) begin
      count_d   = '0;
      wrapped_d = 1'b0;
      halted_d  = 1'b0;
    end else if (load) begin
      count_d  = load_big ? LAST : load_value;
      halted_d = 1'b0;
    end else if (step) begin
      if (!terminal) begin
        count_d = (up_down == COUNT_UP) ? count_N + WIDTH'(1) : count_N - WIDTH'(1);
      end else begin
        wrapped_d = 1'b1;
        if (one_shot == MODE_ONESHOT) halted_d = 1'b1;
        else count_d = (up_down == COUNT_UP) ? '0 : LAST;
      end
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      running <= 1'b0;
      count_N <= '0;
      wrapped <= 1'b0;
      halted  <= 1'b0;
    end else begin
      running <= 1'b1;
      count_N <= count_d;
      wrapped <= wrapped_d;
      halted  <= halted_d;
    end
  end

endmodule : counter_n_param

// File: tb/tb_counter_n_param.sv
// Bench for counter_n_param (WIDTH=3, MODULUS=6): a main stage for the
// functional scenarios plus a two-stage cascade. The driver queues the
// expected outputs; the monitor compares after each rising edge or after
// an asynchronous-reset event.
module tb_counter_n_param;

  logic       clk = 1'b0;
  logic       reset;
  logic       enable, carry_in, clear, load, up_down, one_shot;
  logic [2:0] load_value;
  logic [2:0] count_N;
  logic       carry_out_N, wrapped, halted;

  logic       casc_en;
  logic [2:0] c0_count, c1_count;
  logic       c0_co, c1_co, c0_wr, c1_wr, c0_ha, c1_ha;

  typedef struct {
    string      name;
    logic       sel;   // 0: main stage, 1: cascade pair
    logic [5:0] cnt;
    logic       co;
    logic       wr;
    logic       ha;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;
  event async_ev;

  always #5 clk = ~clk;

  counter_n_param #(.WIDTH(3), .MODULUS(6)) dut (
    .clk(clk), .reset(reset), .enable(enable), .carry_in(carry_in),
    .clear(clear), .load(load), .load_value(load_value), .up_down(up_down),
    .one_shot(one_shot), .count_N(count_N), .carry_out_N(carry_out_N),
    .wrapped(wrapped), .halted(halted)
  );

  counter_n_param #(.WIDTH(3), .MODULUS(6)) stage0 (
    .clk(clk), .reset(reset), .enable(casc_en), .carry_in(1'b1),
    .clear(1'b0), .load(1'b0), .load_value(3'd0), .up_down(1'b1),
    .one_shot(1'b0), .count_N(c0_count), .carry_out_N(c0_co),
    .wrapped(c0_wr), .halted(c0_ha)
  );

  counter_n_param #(.WIDTH(3), .MODULUS(6)) stage1 (
    .clk(clk), .reset(reset), .enable(casc_en), .carry_in(c0_co),
    .clear(1'b0), .load(1'b0), .load_value(3'd0), .up_down(1'b1),
    .one_shot(1'b0), .count_N(c1_count), .carry_out_N(c1_co),
    .wrapped(c1_wr), .halted(c1_ha)
  );

  // Monitor: one queued expectation per rising edge or async event.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk or async_ev);
      #2;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        checks++;
        if (e.sel) begin
          if ({c1_count, c0_count} != e.cnt) begin
            errors++;
            $display("FAIL %s: cascade got %0d%0d expected %0d%0d",
                     e.name, c1_count, c0_count, e.cnt[5:3], e.cnt[2:0]);
          end
        end else if (count_N != e.cnt[2:0] || carry_out_N != e.co ||
                     wrapped != e.wr || halted != e.ha) begin
          errors++;
          $display("FAIL %s: got count=%0d co=%0b wr=%0b ha=%0b expected count=%0d co=%0b wr=%0b ha=%0b",
                   e.name, count_N, carry_out_N, wrapped, halted,
                   e.cnt[2:0], e.co, e.wr, e.ha);
        end
      end
    end
  end

  // Queue the expected main-stage state after the next rising edge.
  task automatic cyc(input string nm, input logic [2:0] c, input logic co,
                     input logic wr, input logic ha);
    exp_t e;
    e.name = nm; e.sel = 1'b0; e.cnt = {3'd0, c}; e.co = co; e.wr = wr; e.ha = ha;
    exp_q.push_back(e);
    @(negedge clk);
  endtask

  // Queue an expectation sampled between edges, right after an async change.
  task automatic now_chk(input string nm, input logic [2:0] c, input logic co,
                         input logic wr, input logic ha);
    exp_t e;
    e.name = nm; e.sel = 1'b0; e.cnt = {3'd0, c}; e.co = co; e.wr = wr; e.ha = ha;
    exp_q.push_back(e);
    ->async_ev;
  endtask

  initial begin
    exp_t ce;
    int   v;
    reset = 1'b0; enable = 1'b1; carry_in = 1'b1; clear = 1'b0; load = 1'b0;
    load_value = 3'd0; up_down = 1'b0; one_shot = 1'b0; casc_en = 1'b0;

    // Reset held: down-direction terminal at 0 must not leak onto carry.
    #1 now_chk("reset_hold", 3'd0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    @(negedge clk);

    // Release: that edge must not step.
    enable = 1'b0; up_down = 1'b1; reset = 1'b1;
    cyc("release", 3'd0, 1'b0, 1'b0, 1'b0);

    // Free-running up count with wrap.
    enable = 1'b1;
    cyc("up1", 3'd1, 1'b0, 1'b0, 1'b0);
    cyc("up2", 3'd2, 1'b0, 1'b0, 1'b0);
    cyc("up3", 3'd3, 1'b0, 1'b0, 1'b0);
    cyc("up4", 3'd4, 1'b0, 1'b0, 1'b0);
    cyc("up5", 3'd5, 1'b1, 1'b0, 1'b0);
    cyc("upwrap0", 3'd0, 1'b0, 1'b1, 1'b0);
    cyc("up1b", 3'd1, 1'b0, 1'b1, 1'b0);
    cyc("up2b", 3'd2, 1'b0, 1'b1, 1'b0);

    // Load 2 then one-shot down count; wrapped stays set through load.
    enable = 1'b0; load = 1'b1; load_value = 3'd2;
    cyc("load2", 3'd2, 1'b0, 1'b1, 1'b0);
    load = 1'b0; enable = 1'b1; up_down = 1'b0; one_shot = 1'b1;
    cyc("dn1", 3'd1, 1'b0, 1'b1, 1'b0);
    cyc("dn0", 3'd0, 1'b1, 1'b1, 1'b0);
    cyc("halt", 3'd0, 1'b0, 1'b1, 1'b1);
    cyc("hold", 3'd0, 1'b0, 1'b1, 1'b1);
    // Dropping one_shot or flipping direction does not release halt.
    one_shot = 1'b0; up_down = 1'b1;
    cyc("hold_mode", 3'd0, 1'b0, 1'b1, 1'b1);
    enable = 1'b0; load = 1'b1; load_value = 3'd4;
    cyc("load4", 3'd4, 1'b0, 1'b1, 1'b0);

    // Direction change mid-count.
    load = 1'b0; enable = 1'b1; up_down = 1'b1;
    cyc("dir_up5", 3'd5, 1'b1, 1'b1, 1'b0);
    up_down = 1'b0;
    cyc("dir_dn4", 3'd4, 1'b0, 1'b1, 1'b0);

    // Priority: clear beats load beats step.
    clear = 1'b1; load = 1'b1; load_value = 3'd3; up_down = 1'b1;
    cyc("prio", 3'd0, 1'b0, 1'b0, 1'b0);
    clear = 1'b0; enable = 1'b0; load_value = 3'd7;
    cyc("clamp7", 3'd5, 1'b0, 1'b0, 1'b0);
    load_value = 3'd0;
    cyc("ld0", 3'd0, 1'b0, 1'b0, 1'b0);
    load_value = 3'd6;
    cyc("clamp6", 3'd5, 1'b0, 1'b0, 1'b0);
    load_value = 3'd0;
    cyc("ld0b", 3'd0, 1'b0, 1'b0, 1'b0);

    // Free-running down wrap, then carry_in blocks counting.
    load = 1'b0; enable = 1'b1; up_down = 1'b0;
    cyc("dn_wrap", 3'd5, 1'b0, 1'b1, 1'b0);
    carry_in = 1'b0;
    cyc("ci_block", 3'd5, 1'b0, 1'b1, 1'b0);
    carry_in = 1'b1;

    // Async reset mid-count at 3.
    clear = 1'b1; enable = 1'b0;
    cyc("clr", 3'd0, 1'b0, 1'b0, 1'b0);
    clear = 1'b0; enable = 1'b1; up_down = 1'b1;
    cyc("c1", 3'd1, 1'b0, 1'b0, 1'b0);
    cyc("c2", 3'd2, 1'b0, 1'b0, 1'b0);
    cyc("c3", 3'd3, 1'b0, 1'b0, 1'b0);
    #1 reset = 1'b0; up_down = 1'b0;
    now_chk("async_rst", 3'd0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    reset = 1'b1; up_down = 1'b1;
    cyc("rel_nostep", 3'd0, 1'b0, 1'b0, 1'b0);
    cyc("first_step", 3'd1, 1'b0, 1'b0, 1'b0);

    // Cascade: 36 edges cover 00..55 and return to 00.
    enable = 1'b0; casc_en = 1'b1;
    for (int k = 1; k <= 36; k++) begin
      v = k % 36;
      ce.name = $sformatf("casc%0d", k);
      ce.sel = 1'b1;
      ce.cnt = {3'(v / 6), 3'(v % 6)};
      ce.co = 1'b0; ce.wr = 1'b0; ce.ha = 1'b0;
      exp_q.push_back(ce);
      @(negedge clk);
    end
    casc_en = 1'b0;

    @(negedge clk);
    @(negedge clk);
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_counter_n_param
